// File: rtl/ws2811_pkg.sv
// Shared types and 60MHz default timing for the WS2811 frame scheduler.
// Imported by the scheduler top and its bit-cell encoder.
package ws2811_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  localparam int DEF_NUM_LEDS  = 50;
  localparam int DEF_BIT_CYC   = 75;
  localparam int DEF_T0H_CYC   = 21;
  localparam int DEF_T1H_CYC   = 42;
  localparam int DEF_LATCH_CYC = 3600;

  function automatic int frame_bytes(input int leds);
    return 3 * leds;
  endfunction

endpackage

// File: rtl/ws2811_bit_encoder.sv
// WS2811 bit-cell generator: one BIT_CYC cell per bit, high for the
// bit's high time. bit_valid is sampled when idle or in the last cell cycle.
module ws2811_bit_encoder #(
  parameter int BIT_CYC = 75,
  parameter int T0H_CYC = 21,
  parameter int T1H_CYC = 42
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_val,
  output logic ws2811,
  output logic bit_last,
  output logic cell0
);

  localparam int CW = $clog2(BIT_CYC);

  logic [CW-1:0] cell_cnt;
  logic          running;
  logic          cur_bit;
  logic          load;

  always_comb begin
    cell0    = running && (cell_cnt == '0);
    bit_last = running && (cell_cnt == CW'(BIT_CYC - 1));
    load     = bit_valid && (!running || bit_last);
  end

  // ws2811 is computed one cycle ahead so it lines up with cell_cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      cell_cnt <= '0;
      cur_bit  <= 1'b0;
      ws2811   <= 1'b0;
    end else if (load) begin
      running  <= 1'b1;
      cell_cnt <= '0;
      cur_bit  <= bit_val;
      ws2811   <= (bit_val ? T1H_CYC : T0H_CYC) > 0;
    end else if (!running || bit_last) begin
      running  <= 1'b0;
      cell_cnt <= '0;
      ws2811   <= 1'b0;
    end else begin
      cell_cnt <= cell_cnt + CW'(1);
      ws2811   <= (int'(cell_cnt) + 1) <
                  (cur_bit ? T1H_CYC : T0H_CYC);
    end
  end

endmodule

// File: rtl/ws2811_frame_scheduler.sv
// WS2811 frame scheduler: pulls GRB bytes from the FIFO read port,
// streams gapless bit cells, then holds the latch low time.
module ws2811_frame_scheduler
  import ws2811_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int LATCH_CYC = DEF_LATCH_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdreq,
  output logic       ws2811,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int NBYTES = frame_bytes(NUM_LEDS);
  localparam int BW     = $clog2(NBYTES + 1);
  localparam int LW     = $clog2(LATCH_CYC + 1);

  state_t        state;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    next_reg;
  logic          next_valid;
  logic          cap_next;
  logic          start_pend;
  logic [LW-1:0] latch_cnt;

  logic accept;
  logic bit_valid;
  logic bit_val;
  logic bit_last;
  logic cell0;
  logic pf_slot;

  ws2811_bit_encoder #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) u_enc (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .ws2811    (ws2811),
    .bit_last  (bit_last),
    .cell0     (cell0)
  );

  always_comb begin
    accept  = (state == ST_IDLE) && (start_pend || start) &&
              !fifo_empty;
    pf_slot = (state == ST_SHIFT) && cell0 && (bit_idx == 3'd0) &&
              (byte_cnt < BW'(NBYTES));
  end

  // Next cell is handed over in the last cycle of the current one
  always_comb begin
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    if (state == ST_CAPTURE) begin
      bit_valid = 1'b1;
      bit_val   = fifo_q[7];
    end else if (state == ST_SHIFT && bit_last) begin
      if (bit_idx != 3'd0) begin
        bit_valid = 1'b1;
        bit_val   = shift_reg[bit_idx - 3'd1];
      end else if (next_valid) begin
        bit_valid = 1'b1;
        bit_val   = next_reg[7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      next_reg   <= '0;
      next_valid <= 1'b0;
      cap_next   <= 1'b0;
      start_pend <= 1'b0;
      latch_cnt  <= '0;
      fifo_rdreq <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fifo_rdreq <= 1'b0;
      frame_done <= 1'b0;
      cap_next   <= fifo_rdreq && (state == ST_SHIFT);
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_FETCH;
            busy       <= 1'b1;
            underrun   <= 1'b0;
            byte_cnt   <= '0;
            next_valid <= 1'b0;
            start_pend <= 1'b0;
            fifo_rdreq <= 1'b1;
          end else begin
            busy       <= 1'b0;
            start_pend <= start_pend || start;
          end
        end
        ST_FETCH: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          shift_reg <= fifo_q;
          byte_cnt  <= byte_cnt + BW'(1);
          bit_idx   <= 3'd7;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (pf_slot && !fifo_empty) begin
            fifo_rdreq <= 1'b1;
          end
          if (cap_next) begin
            next_reg   <= fifo_q;
            next_valid <= 1'b1;
            byte_cnt   <= byte_cnt + BW'(1);
          end
          if (bit_last) begin
            if (bit_idx != 3'd0) begin
              bit_idx <= bit_idx - 3'd1;
            end else if (next_valid) begin
              shift_reg  <= next_reg;
              next_valid <= 1'b0;
              bit_idx    <= 3'd7;
            end else begin
              // Short frame means the prefetch found the FIFO empty
              underrun  <= (byte_cnt != BW'(NBYTES));
              latch_cnt <= '0;
              state     <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (latch_cnt == LW'(LATCH_CYC - 1)) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            latch_cnt <= latch_cnt + LW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_frame_scheduler.sv
// Self-checking bench for ws2811_frame_scheduler with a queue-based
// FIFO model and a per-cell waveform reference.
module tb_ws2811_frame_scheduler;

  localparam int NL = 2;
  localparam int BC = 8;
  localparam int T0 = 2;
  localparam int T1 = 5;
  localparam int LC = 20;
  localparam int NB = 3 * NL;

  typedef logic [5:0][7:0] frame_t;

  typedef struct {
    int     pre;
    int     n;
    frame_t d;
    int     cells;
    bit     ur;
    int     rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_rdreq;
  logic       ws2811;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fq[$];

  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int viol_rd  = 0;
  int viol_ws  = 0;

  always #5 clk = ~clk;

  ws2811_frame_scheduler #(
    .NUM_LEDS  (NL),
    .BIT_CYC   (BC),
    .T0H_CYC   (T0),
    .T1H_CYC   (T1),
    .LATCH_CYC (LC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .ws2811     (ws2811),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // Non-show-ahead FIFO: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (fifo_rdreq && fq.size() > 0) fifo_q <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
    if (fifo_rdreq) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) begin
    if (fifo_rdreq && fifo_empty) viol_rd++;
    if (ws2811 && !busy) viol_ws++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] b0, b1, b2,
                                b3, b4, b5);
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic push_bytes(input frame_t d, input int from,
                            input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = d[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_rise(output int k, input int budget);
    k = 0;
    while (!ws2811 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Reference: cell j carries bit (7 - j%8) of byte j/8, high T1 or T0
  task automatic check_frame(input frame_t d, input int ncells,
                             input bit exp_ur, input bit b2b);
    int k;
    int h;
    int bad;
    logic [7:0] obs;
    logic [7:0] exp;
    wait_rise(k, 200);
    check("first_rise", ws2811, 1);
    for (int j = 0; j < ncells; j++) begin
      h = d[j / 8][7 - (j % 8)] ? T1 : T0;
      for (int c = 0; c < BC; c++) begin
        obs[c] = ws2811;
        exp[c] = (c < h);
        @(negedge clk);
      end
      check($sformatf("cell%0d", j), obs, exp);
    end
    bad = 0;
    for (int c = 0; c < LC; c++) begin
      if (ws2811 || frame_done || !busy) bad++;
      @(negedge clk);
    end
    check("latch_low", bad, 0);
    check("frame_done", frame_done, 1);
    check("underrun", underrun, exp_ur);
    if (!b2b) begin
      @(negedge clk);
      check("done_one_cycle", frame_done, 0);
      check("busy_clear", busy, 0);
    end
  endtask

  task automatic run_frame(input frame_t d, input int pre,
                           input int n, input int cells,
                           input bit ur, input int rd);
    int rd0;
    int k;
    push_bytes(d, pre, n);
    rd0   = rd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ur_cleared", underrun, 0);
    check("fetch_rdreq", fifo_rdreq, 1);
    check("busy_set", busy, 1);
    k = 1;
    while (!ws2811 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, 3);
    check_frame(d, cells, ur, 1'b0);
    check("rdreq_count", rd_cnt - rd0, rd);
  endtask

  vec_t   tbl[4];
  frame_t d3, d4, d5a, d5b, dr;
  int     k, bad, n;

  initial begin
    tbl[0] = '{0, 6, mk(8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h7E),
               48, 1'b0, 6};
    tbl[1] = '{0, 4, mk(8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00),
               32, 1'b1, 4};
    tbl[2] = '{0, 1, mk(8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00),
               8, 1'b1, 1};
    tbl[3] = '{0, 6, mk(8'hFF, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h3C),
               48, 1'b0, 6};
    d3  = mk(8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'h99);
    d4  = mk(8'h5A, 8'hC0, 8'h03, 8'h6D, 8'hB2, 8'h11);
    d5a = mk(8'hF0, 8'h0F, 8'hCC, 8'h33, 8'h96, 8'h69);
    d5b = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20);

    repeat (3) @(negedge clk);
    check("rst_ws2811", ws2811, 0);
    check("rst_busy", busy, 0);
    check("rst_rdreq", fifo_rdreq, 0);
    check("rst_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_frame(tbl[i].d, tbl[i].pre, tbl[i].n, tbl[i].cells,
                tbl[i].ur, tbl[i].rd);

    // Start on empty FIFO, data arrives later
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("empty_no_accept", busy, 0);
    wr_en   = 1'b1;
    wr_data = d3[0];
    @(negedge clk);
    wr_en = 1'b0;
    check("empty_fell", fifo_empty, 0);
    check("rdreq_not_yet", fifo_rdreq, 0);
    @(negedge clk);
    check("rdreq_rise", fifo_rdreq, 1);
    fork
      check_frame(d3, 48, 1'b0, 1'b0);
      begin
        for (int i = 1; i < 6; i++) begin
          @(negedge clk);
          wr_en   = 1'b1;
          wr_data = d3[i];
        end
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          wr_en   = 1'b1;
          wr_data = d4[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) begin
          repeat (30) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    repeat (20) @(negedge clk);
    check("no_second_frame", busy, 0);

    // Reset mid-frame, in cell 20
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rise(k, 50);
    check("t4_rise", ws2811, 1);
    repeat (20 * BC) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ws", ws2811, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rdreq", fifo_rdreq, 0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy || frame_done || ws2811) bad++;
      @(negedge clk);
    end
    check("rst_mid_quiet", bad, 0);
    run_frame(mk(d4[3], d4[4], d4[5], 8'hDE, 8'hAD, 8'hBE), 3, 6,
              48, 1'b0, 6);

    // Start held high with two frames queued
    push_bytes(d5a, 0, 6);
    push_bytes(d5b, 0, 6);
    start = 1'b1;
    check_frame(d5a, 48, 1'b0, 1'b1);
    k = 0;
    while (!ws2811 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("b2b_restart", k, 3);
    start = 1'b0;
    check_frame(d5b, 48, 1'b0, 1'b0);

    // Random frames against the reference rules
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, NB);
      for (int i = 0; i < 6; i++) dr[i] = 8'($urandom);
      run_frame(dr, 0, n, 8 * n, n < NB, n);
    end

    check("no_rdreq_when_empty", viol_rd, 0);
    check("no_ws_when_idle", viol_ws, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
